// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/execute sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EXEC,
    ST_HALT,
    ST_FAULT
  } fetch_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE            = 2'd0,
    FAULT_FETCH_MISALIGN  = 2'd1,
    FAULT_BRANCH_MISALIGN = 2'd2,
    FAULT_TIMEOUT         = 2'd3
  } fetch_fault_t;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0010_0073;

  // Counter width able to hold 0..limit, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read port: request/ready handshake plus read-data return.
interface fetch_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rvalid, input rdata);
  modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts WAIT cycles; terminal fires on the increment that would reach LIMIT.
module fetch_timeout_counter
  import fetch_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic terminal
);

  localparam int            CW   = cnt_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (inc)     cnt <= cnt + CW'(1);
  end

  // LIMIT of zero disables the fault; the counter then just free-runs harmlessly.
  assign terminal = (LIMIT != 0) && inc && (cnt == LAST);

endmodule

// File: rtl/register.sv
// Generic enabled register with synchronous active-high reset.
module Register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: reads imem at pc, hands the word to execute,
// then steps or redirects the PC; detects halt, misalignment and timeout.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 255,
  parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic [31:0]               pc,
  fetch_sequencer_if.master         imem,
  output logic [31:0]               instr,
  output logic                      instr_valid,
  input  logic                      exec_done,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_target,
  output logic                      pc_enable,
  output logic                      jump_en,
  output logic [31:0]               jump_to,
  output logic                      halted,
  output logic                      fault,
  output logic [1:0]                fault_code,
  output logic [31:0]               instret
);

  fetch_state_t state;
  fetch_fault_t fcode;

  logic pc_misalign, br_misalign, is_halt, capture, tmo_hit, retire;

  assign pc_misalign = (pc[1:0] != 2'b00);
  assign br_misalign = branch_taken && (branch_target[1:0] != 2'b00);
  assign is_halt     = (instr == HALT_INSTR);
  assign capture     = (state == ST_WAIT) && imem.rvalid;

  Register #(.WIDTH(32)) u_instr_reg (
    .clk   (clk),
    .reset (reset),
    .en    (capture),
    .d     (imem.rdata),
    .q     (instr)
  );

  fetch_timeout_counter #(.LIMIT(MEM_TIMEOUT)) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .clr      ((state == ST_REQ) && imem.ready),
    .inc      ((state == ST_WAIT) && !imem.rvalid),
    .terminal (tmo_hit)
  );

  // PC controls are combinational so the PC register updates on the very
  // edge that samples exec_done.
  assign retire    = (state == ST_EXEC) && exec_done && !is_halt && !br_misalign;
  assign pc_enable = retire;
  assign jump_en   = retire && branch_taken;
  assign jump_to   = branch_target;
  assign imem.req  = (state == ST_REQ) && !pc_misalign;
  assign imem.addr = pc;
  assign fault_code = fcode;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fcode       <= FAULT_NONE;
      instret     <= '0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        ST_IDLE: if (run) state <= ST_REQ;
        ST_REQ: begin
          if (pc_misalign) begin
            state <= ST_FAULT;
            fault <= 1'b1;
            fcode <= FAULT_FETCH_MISALIGN;
          end else if (imem.ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Data arriving on the terminal-count cycle still wins.
          if (imem.rvalid) begin
            state       <= ST_EXEC;
            instr_valid <= 1'b1;
          end else if (tmo_hit) begin
            state <= ST_FAULT;
            fault <= 1'b1;
            fcode <= FAULT_TIMEOUT;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            if (is_halt) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else if (br_misalign) begin
              state <= ST_FAULT;
              fault <= 1'b1;
              fcode <= FAULT_BRANCH_MISALIGN;
            end else begin
              instret <= instret + 32'd1;
              state   <= run ? ST_REQ : ST_IDLE;
            end
          end
        end
        ST_HALT:  state <= ST_HALT;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table plus multi-cycle corner sequences.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        pc_enable;
  logic        jump_en;
  logic [31:0] jump_to;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] instret;

  logic        pc_set;
  logic [31:0] pc_set_val;

  int checks = 0;
  int errors = 0;

  fetch_sequencer_if imem_if ();

  fetch_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .pc            (pc),
    .imem          (imem_if),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_enable     (pc_enable),
    .jump_en       (jump_en),
    .jump_to       (jump_to),
    .halted        (halted),
    .fault         (fault),
    .fault_code    (fault_code),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  // Program-counter model driven by the sequencer's strobes.
  always @(posedge clk) begin
    if (reset)          pc <= 32'd0;
    else if (pc_set)    pc <= pc_set_val;
    else if (pc_enable) pc <= jump_en ? jump_to : pc + 32'd4;
  end

  typedef struct {
    logic        run, rdy, rv;
    logic [31:0] rdata;
    logic        done, bt;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        pce, jen, iv, flt;
    logic [1:0]  code;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic dn, input logic bt, input logic [31:0] tgt);
    run = r; imem_if.ready = rdy; imem_if.rvalid = rv; imem_if.rdata = rd;
    exec_done = dn; branch_taken = bt; branch_target = tgt;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cyc();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(logic [31:0] tgt, logic bt, logic req, logic [31:0] addr,
                              logic pce, logic jen, logic iv, logic flt, logic [1:0] code,
                              logic [31:0] ret);
    vec_t v;
    v.run = 1'b1; v.rdy = 1'b1; v.rv = 1'b1; v.rdata = NOP; v.done = 1'b1;
    v.bt = bt; v.tgt = tgt; v.req = req; v.addr = addr; v.pce = pce; v.jen = jen;
    v.iv = iv; v.flt = flt; v.code = code; v.ret = ret;
    return v;
  endfunction

  initial begin
    pc_set = 1'b0; pc_set_val = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cyc(); cyc();
    chk("rst_req", 32'(imem_if.req), 32'd0);
    chk("rst_pce", 32'(pc_enable), 32'd0);
    chk("rst_jen", 32'(jump_en), 32'd0);
    chk("rst_iv", 32'(instr_valid), 32'd0);
    chk("rst_halt", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instret", instret, 32'd0);
    reset = 1'b0;

    // Straight-line fetch, then a taken branch, then a misaligned branch.
    //           tgt        bt    req   addr     pce   jen   iv    flt   code  ret
    vecs.push_back(mk(32'h0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0)); // IDLE
    vecs.push_back(mk(32'h0, 1'b0, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0)); // REQ
    vecs.push_back(mk(32'h0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0)); // WAIT
    vecs.push_back(mk(32'h0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0)); // EXEC
    vecs.push_back(mk(32'h0, 1'b0, 1'b1, 32'h4,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd1));
    vecs.push_back(mk(32'h0, 1'b0, 1'b0, 32'h4,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd1));
    vecs.push_back(mk(32'h0, 1'b0, 1'b0, 32'h4,   1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'd1));
    vecs.push_back(mk(32'h0, 1'b0, 1'b1, 32'h8,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd2));
    vecs.push_back(mk(32'h0, 1'b0, 1'b0, 32'h8,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd2));
    vecs.push_back(mk(32'h0, 1'b0, 1'b0, 32'h8,   1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'd2));
    vecs.push_back(mk(32'h0, 1'b0, 1'b1, 32'hc,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd3));
    vecs.push_back(mk(32'h0, 1'b0, 1'b0, 32'hc,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd3));
    vecs.push_back(mk(32'h0, 1'b0, 1'b0, 32'hc,   1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'd3));
    vecs.push_back(mk(32'h0, 1'b0, 1'b1, 32'h10,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd4));
    vecs.push_back(mk(32'h0, 1'b0, 1'b0, 32'h10,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd4));
    vecs.push_back(mk(32'h100, 1'b1, 1'b0, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'd4)); // taken
    vecs.push_back(mk(32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd5));
    vecs.push_back(mk(32'h0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd5));
    vecs.push_back(mk(32'h102, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd5)); // bad target
    vecs.push_back(mk(32'h102, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'd5));
    vecs.push_back(mk(32'h102, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'd5));

    foreach (vecs[i]) begin
      set_in(vecs[i].run, vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].done,
             vecs[i].bt, vecs[i].tgt);
      chk($sformatf("v%0d_req", i), 32'(imem_if.req), 32'(vecs[i].req));
      chk($sformatf("v%0d_addr", i), imem_if.addr, vecs[i].addr);
      chk($sformatf("v%0d_pce", i), 32'(pc_enable), 32'(vecs[i].pce));
      chk($sformatf("v%0d_jen", i), 32'(jump_en), 32'(vecs[i].jen));
      chk($sformatf("v%0d_iv", i), 32'(instr_valid), 32'(vecs[i].iv));
      chk($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].flt));
      chk($sformatf("v%0d_code", i), 32'(fault_code), 32'(vecs[i].code));
      chk($sformatf("v%0d_instret", i), instret, vecs[i].ret);
      if (vecs[i].jen) chk($sformatf("v%0d_jump_to", i), jump_to, 32'h100);
      cyc();
    end

    // Fetch misalignment: pc=6 in REQ faults without a request.
    do_reset();
    pc_set = 1'b1; pc_set_val = 32'h6;
    set_in(1'b1, 1'b1, 1'b0, NOP, 1'b0, 1'b0, 32'd0);
    cyc();
    pc_set = 1'b0;
    #1;
    chk("fmis_req", 32'(imem_if.req), 32'd0);
    chk("fmis_addr", imem_if.addr, 32'h6);
    cyc();
    chk("fmis_fault", 32'(fault), 32'd1);
    chk("fmis_code", 32'(fault_code), 32'd1);
    chk("fmis_req2", 32'(imem_if.req), 32'd0);

    // Timeout after the fourth WAIT cycle.
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, NOP, 1'b0, 1'b0, 32'd0);
    cyc(); cyc();
    for (int w = 1; w <= 4; w++) begin
      chk($sformatf("tmo_w%0d_fault", w), 32'(fault), 32'd0);
      cyc();
    end
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_code", 32'(fault_code), 32'd3);

    // rvalid on the terminal-count cycle wins over the timeout.
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, NOP, 1'b0, 1'b0, 32'd0);
    cyc(); cyc(); cyc(); cyc(); cyc();
    set_in(1'b0, 1'b1, 1'b1, NOP, 1'b0, 1'b0, 32'd0);
    cyc();
    chk("tmo_race_iv", 32'(instr_valid), 32'd1);
    chk("tmo_race_fault", 32'(fault), 32'd0);
    chk("tmo_race_instr", instr, NOP);

    // Halt: no retire, no further PC updates.
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, HALT, 1'b1, 1'b0, 32'd0);
    cyc(); cyc(); cyc();
    chk("halt_exec_iv", 32'(instr_valid), 32'd1);
    chk("halt_exec_pce", 32'(pc_enable), 32'd0);
    cyc();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_instret", instret, 32'd0);
    chk("halt_fault", 32'(fault), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("halt_hold%0d_pce", k), 32'(pc_enable), 32'd0);
      cyc();
    end
    chk("halt_stays", 32'(halted), 32'd1);

    // Reset during WAIT, then restart with run.
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, NOP, 1'b1, 1'b0, 32'd0);
    cyc(); cyc(); cyc(); cyc();
    set_in(1'b1, 1'b1, 1'b0, NOP, 1'b1, 1'b0, 32'd0);
    cyc();
    chk("rstw_instret_pre", instret, 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("rstw_req", 32'(imem_if.req), 32'd0);
    chk("rstw_instret", instret, 32'd0);
    chk("rstw_instr", instr, 32'd0);
    chk("rstw_iv", 32'(instr_valid), 32'd0);
    chk("rstw_pce", 32'(pc_enable), 32'd0);
    chk("rstw_fault", 32'(fault), 32'd0);
    cyc();
    chk("rstw_idle_req", 32'(imem_if.req), 32'd0);
    set_in(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cyc();
    chk("rstw_restart_req", 32'(imem_if.req), 32'd1);
    chk("rstw_restart_addr", imem_if.addr, 32'd0);

    // run dropped before retire: retire still happens, then IDLE.
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, NOP, 1'b0, 1'b0, 32'd0);
    cyc();
    set_in(1'b0, 1'b1, 1'b1, NOP, 1'b0, 1'b0, 32'd0);
    cyc(); cyc();
    set_in(1'b0, 1'b1, 1'b1, NOP, 1'b1, 1'b0, 32'd0);
    chk("rund_pce", 32'(pc_enable), 32'd1);
    cyc();
    chk("rund_req", 32'(imem_if.req), 32'd0);
    chk("rund_instret", instret, 32'd1);
    chk("rund_addr", imem_if.addr, 32'd4);
    cyc();
    chk("rund_idle_req", 32'(imem_if.req), 32'd0);
    chk("rund_idle_pce", 32'(pc_enable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
